// File: rtl/mont_mult.sv
`default_nettype none
// ============================================================================
// Module   : mont_mult
// Purpose  : Bit-serial radix-2 Montgomery multiplier, a*b*2^-WIDTH mod n.
//            Optional macro MONT_FINAL_SUB_EN adds the final conditional
//            subtraction state (result_o < n_i); otherwise result_o < 2*n_i.
// Revision : 1.0 - initial release
// ============================================================================
module mont_mult #(
   parameter int WIDTH = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] n_i,
   output logic             ready,
   output logic             done,
   output logic [WIDTH:0]   result_o
);

   localparam int                 c_CNT_W = $clog2(WIDTH + 1);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOOP  = 2'd1,
      S_FINAL = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_n;
   logic [WIDTH+1:0]   r_m;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_done;
   logic [WIDTH:0]     r_result;

   logic               w_last;
   logic               w_load;
   logic               w_step;
   logic               w_finish;
   logic [WIDTH+1:0]   w_m1;
   logic [WIDTH+1:0]   w_m2;
   logic [WIDTH+1:0]   w_m_nxt;
   logic [WIDTH:0]     w_result;

   // One Montgomery iteration; the multiplier is shifted so bit i sits at r_a[0].
   // M < 2N keeps M2 < 4N, so WIDTH+2 bits never lose a carry.
   always_comb begin
      w_m1    = r_m + (r_a[0] ? {2'b00, r_b} : '0);
      w_m2    = w_m1 + (w_m1[0] ? {2'b00, r_n} : '0);
      w_m_nxt = w_m2 >> 1;
   end

   assign w_last = (r_cnt == c_LAST);

`ifdef MONT_FINAL_SUB_EN
   logic [WIDTH:0] w_diff;
   logic           w_ge;

   // Top bit of r_m is zero here since M < 2N < 2^(WIDTH+1).
   assign w_ge     = (r_m >= {2'b00, r_n});
   assign w_diff   = r_m[WIDTH:0] - {1'b0, r_n};
   assign w_result = w_ge ? w_diff : r_m[WIDTH:0];
`else
   assign w_result = w_m_nxt[WIDTH:0];
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      ready       = 1'b0;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = S_LOOP;
            end
         end
         S_LOOP: begin
            w_step = 1'b1;
            if (w_last) begin
`ifdef MONT_FINAL_SUB_EN
               w_state_nxt = S_FINAL;
`else
               w_state_nxt = S_IDLE;
               w_finish    = 1'b1;
`endif
            end
         end
         S_FINAL: begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_n      <= '0;
         r_m      <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= w_finish;
         if (w_load) begin
            r_a   <= a_i;
            r_b   <= b_i;
            r_n   <= n_i;
            r_m   <= '0;
            r_cnt <= '0;
         end else if (w_step) begin
            r_a   <= r_a >> 1;
            r_m   <= w_m_nxt;
            r_cnt <= r_cnt + c_ONE;
         end
         if (w_finish) begin
            r_result <= w_result;
         end
      end
   end

   assign done     = r_done;
   assign result_o = r_result;

endmodule
`default_nettype wire
